xof_coef_unpacker: RTL and testbench

- Squeeze-side consumer and requester for the shake256 sponge core.
- Accepts a request for N coefficients and computes the XOF output length in bytes.
- Pulses the sponge start, then consumes the 64-bit keep-qualified squeeze stream.
- Unpacks a little-endian bitstream into COEF_W-bit coefficients, one per handshake. These feed LWR matrix/vector generation downstream.

---
 rtl/xof_coef_unpacker_pkg.sv | 27 ++
 rtl/xof_coef_unpacker_bit_unpack_buf.sv | 65 ++++++
 rtl/xof_coef_unpacker.sv | 144 ++++++++++++++
 tb/tb_xof_coef_unpacker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xof_coef_unpacker_pkg.sv
// Shared definitions for the XOF coefficient unpacker: FSM encoding, length
// limits and the keep-to-byte-count helper also used by the sponge.
package xof_coef_unpacker_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int LEN_W   = 13;
    localparam int MAX_LEN = 8191;
    // Bit counter width; holds up to 127, enough for BUF_W <= 79.
    localparam int CNT_W   = 7;

    function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/xof_coef_unpacker_bit_unpack_buf.sv
// Little-endian bit buffer: appends keep-qualified squeeze words at the
// current fill level and pops COEF_W bits from the bottom.
module xof_coef_unpacker_bit_unpack_buf
    import xof_coef_unpacker_pkg::*;
#(
    parameter int COEF_W = 13,
    parameter int BUF_W  = 64 + COEF_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [63:0]       data_i,
    input  logic [7:0]        keep_i,
    input  logic              pop_i,
    output logic [COEF_W-1:0] coef_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);

    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      lane_mask_s;
    logic [BUF_W-1:0] word_ext_s;

    // Invalid lanes are zeroed so bits above the fill level always stay clear.
    always_comb begin
        lane_mask_s = 64'd0;
        for (int i = 0; i < 8; i++) begin
            lane_mask_s[8*i +: 8] = keep_i[i] ? 8'hFF : 8'h00;
        end
        word_ext_s = BUF_W'(data_i & lane_mask_s);
    end

    always_comb begin
        bits_d = bits_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            bits_d = '0;
            cnt_d  = '0;
        end else if (push_i) begin
            bits_d = bits_q | (word_ext_s << cnt_q);
            cnt_d  = cnt_q + CNT_W'({keep_bytes(keep_i), 3'b000});
        end else if (pop_i) begin
            bits_d = bits_q >> COEF_W;
            cnt_d  = cnt_q - CNT_W'(COEF_W);
        end else begin
            bits_d = bits_q;
            cnt_d  = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
            cnt_q  <= '0;
        end else begin
            bits_q <= bits_d;
            cnt_q  <= cnt_d;
        end
    end

    assign coef_o    = bits_q[COEF_W-1:0];
    assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/xof_coef_unpacker.sv
// Requests N*COEF_W bits from the shake256 squeeze stream and unpacks them
// into COEF_W-bit coefficients with a valid/ready handshake.
module xof_coef_unpacker
    import xof_coef_unpacker_pkg::*;
#(
    parameter int COEF_W = 13,
    parameter int BUF_W  = 64 + COEF_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_num_coefs,
    output logic              xof_start,
    output logic [LEN_W-1:0]  xof_out_len,
    input  logic [63:0]       xof_data,
    input  logic [7:0]        xof_keep,
    input  logic              xof_valid,
    output logic              xof_ready,
    input  logic              xof_last,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic              done,
    output logic              err
);

    localparam int PROD_W = 17;

    state_e             state_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [LEN_W-1:0]   out_len_q;
    logic               xof_start_q;
    logic               done_q;
    logic               err_q;

    logic [PROD_W-1:0]  bits_s;
    logic [PROD_W-1:0]  len_full_s;
    logic               oversize_s;
    logic [CNT_W-1:0]   bit_cnt_s;
    logic               streaming_s;
    logic               have_coef_s;
    logic               xof_hs_s;
    logic               coef_hs_s;
    logic               clr_s;

    // Byte length of the requested bitstream, rounded up to whole bytes.
    always_comb begin
        bits_s     = PROD_W'(req_num_coefs) * PROD_W'(COEF_W);
        len_full_s = (bits_s + 17'd7) >> 3;
        oversize_s = (len_full_s > PROD_W'(MAX_LEN));
    end

    assign streaming_s = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign have_coef_s = (bit_cnt_s >= CNT_W'(COEF_W));
    assign xof_ready   = (state_q == S_STREAM) && !have_coef_s;
    assign coef_valid  = streaming_s && have_coef_s && (remaining_q != 13'd0);
    assign coef_last   = coef_valid && (remaining_q == 13'd1);
    assign req_ready   = (state_q == S_IDLE);
    assign xof_hs_s    = xof_valid && xof_ready;
    assign coef_hs_s   = coef_valid && coef_ready;
    assign clr_s       = (state_q == S_IDLE);

    assign xof_start   = xof_start_q;
    assign xof_out_len = out_len_q;
    assign done        = done_q;
    assign err         = err_q;

    xof_coef_unpacker_bit_unpack_buf #(
        .COEF_W (COEF_W),
        .BUF_W  (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_s),
        .push_i    (xof_hs_s),
        .data_i    (xof_data),
        .keep_i    (xof_keep),
        .pop_i     (coef_hs_s),
        .coef_o    (coef_data),
        .bit_cnt_o (bit_cnt_s)
    );

    // Control FSM; start/done/err are one-cycle registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= 13'd0;
            out_len_q   <= 13'd0;
            xof_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            xof_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (req_num_coefs == 13'd0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (oversize_s) begin
                            err_q <= 1'b1;
                        end else begin
                            remaining_q <= req_num_coefs;
                            out_len_q   <= LEN_W'(len_full_s);
                            xof_start_q <= 1'b1;
                            state_q     <= S_START;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_STREAM;
                end
                S_STREAM, S_DRAIN: begin
                    if (coef_hs_s) begin
                        remaining_q <= remaining_q - 13'd1;
                        if (remaining_q == 13'd1) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (state_q == S_STREAM) begin
                        if (xof_hs_s && xof_last) begin
                            state_q <= S_DRAIN;
                        end
                    end else if (!have_coef_s && (remaining_q != 13'd0)) begin
                        // Sponge ended the stream before enough bits arrived.
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xof_coef_unpacker.sv
// Directed bench for xof_coef_unpacker: a request table run against a
// bit-indexed golden unpacker, plus fixed-data, short-stream and reset cases.
module tb_xof_coef_unpacker;
    import xof_coef_unpacker_pkg::*;

    localparam int W = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [12:0]   req_num_coefs = 13'd0;
    logic          xof_start;
    logic [12:0]   xof_out_len;
    logic [63:0]   xof_data = 64'd0;
    logic [7:0]    xof_keep = 8'd0;
    logic          xof_valid = 1'b0;
    logic          xof_ready;
    logic          xof_last = 1'b0;
    logic [W-1:0]  coef_data;
    logic          coef_valid;
    logic          coef_ready = 1'b0;
    logic          coef_last;
    logic          done;
    logic          err;

    int total = 0;
    int bad   = 0;
    logic [7:0]   stream_b[$];
    logic [W-1:0] got_q[$];

    always #5 clk = ~clk;

    xof_coef_unpacker #(.COEF_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_num_coefs (req_num_coefs),
        .xof_start     (xof_start),
        .xof_out_len   (xof_out_len),
        .xof_data      (xof_data),
        .xof_keep      (xof_keep),
        .xof_valid     (xof_valid),
        .xof_ready     (xof_ready),
        .xof_last      (xof_last),
        .coef_data     (coef_data),
        .coef_valid    (coef_valid),
        .coef_ready    (coef_ready),
        .coef_last     (coef_last),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gold(input int i);
        logic [W-1:0] r;
        logic [7:0]   bv;
        int           idx;
        r = '0;
        for (int b = 0; b < W; b++) begin
            idx  = i * W + b;
            bv   = stream_b[idx / 8];
            r[b] = bv[idx % 8];
        end
        return r;
    endfunction

    task automatic fill_random(input int n);
        stream_b.delete();
        for (int i = 0; i < n; i++) stream_b.push_back(8'($urandom_range(0, 255)));
    endtask

    // One request: exp_len==0 means no xof_start is expected.
    task automatic run_txn(input string tag, input int num, input int feed,
                           input int exp_len, input bit exp_err, input bit rnd);
        int exp_n, words, w, cyc, n_start, n_done, n_err, done_cyc, last_cyc, err_cyc;
        bit started, stall;
        logic [W-1:0] stall_data;
        logic [63:0]  wd;
        logic [7:0]   kp;
        int idx;
        exp_n   = exp_err ? (((feed * 8) / W < num) ? (feed * 8) / W : num) : num;
        words   = (feed + 7) / 8;
        w = 0; cyc = 0; n_start = 0; n_done = 0; n_err = 0;
        done_cyc = -1; last_cyc = -1; err_cyc = -1;
        started = 1'b0; stall = 1'b0; stall_data = '0;
        got_q.delete();

        @(negedge clk);
        check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_num_coefs = num[12:0];
        @(negedge clk);
        req_valid = 1'b0;

        while (cyc < 20000 && n_done == 0 && n_err == 0) begin
            if (xof_start) begin
                n_start++;
                started = 1'b1;
                check({tag, " out_len"}, {19'd0, xof_out_len}, exp_len);
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (err)  begin n_err++;  err_cyc  = cyc; end
            if (stall) begin
                check({tag, " stall_valid"}, {31'd0, coef_valid}, 32'd1);
                check({tag, " stall_data"}, {19'd0, coef_data}, {19'd0, stall_data});
            end
            xof_valid = started && (w < words);
            wd = 64'd0; kp = 8'd0;
            for (int b = 0; b < 8; b++) begin
                idx = 8 * w + b;
                if (idx < feed) begin
                    wd[8*b +: 8] = stream_b[idx];
                    kp[b] = 1'b1;
                end else begin
                    wd[8*b +: 8] = 8'($urandom_range(0, 255));
                end
            end
            xof_data   = wd;
            xof_keep   = kp;
            xof_last   = (w == words - 1);
            coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (xof_valid && xof_ready) w++;
            if (coef_valid && coef_ready) begin
                got_q.push_back(coef_data);
                check({tag, " coef_last"}, {31'd0, coef_last}, {31'd0, got_q.size() == num});
                if (coef_last) last_cyc = cyc;
            end
            stall      = coef_valid && !coef_ready;
            stall_data = coef_data;
            cyc++;
            @(negedge clk);
        end
        xof_valid  = 1'b0;
        coef_ready = 1'b0;

        check({tag, " timeout"}, {31'd0, cyc < 20000}, 32'd1);
        check({tag, " n_start"}, n_start, (exp_len != 0) ? 32'd1 : 32'd0);
        check({tag, " n_done"}, n_done, exp_err ? 32'd0 : 32'd1);
        check({tag, " n_err"}, n_err, exp_err ? 32'd1 : 32'd0);
        check({tag, " n_coefs"}, got_q.size(), exp_n);
        for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
            check({tag, " coef_data"}, {19'd0, got_q[i]}, {19'd0, gold(i)});
        end
        if (!exp_err && num == 0) check({tag, " done_cyc"}, done_cyc, 32'd0);
        if (!exp_err && num != 0) begin
            check({tag, " done_after_last"}, done_cyc, last_cyc + 1);
            check({tag, " words"}, w, words);
        end
        if (exp_err && exp_len == 0) check({tag, " err_cyc"}, err_cyc, 32'd0);

        @(negedge clk);
        check({tag, " idle_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, " idle_valid"}, {31'd0, coef_valid}, 32'd0);
    endtask

    typedef struct {
        int num;
        int feed;
        int exp_len;
        bit exp_err;
        bit rnd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{num: 1,    feed: 2,    exp_len: 2,    exp_err: 1'b0, rnd: 1'b0};
        tbl[1] = '{num: 8,    feed: 13,   exp_len: 13,   exp_err: 1'b0, rnd: 1'b1};
        tbl[2] = '{num: 0,    feed: 0,    exp_len: 0,    exp_err: 1'b0, rnd: 1'b0};
        tbl[3] = '{num: 16,   feed: 26,   exp_len: 26,   exp_err: 1'b0, rnd: 1'b1};
        tbl[4] = '{num: 512,  feed: 832,  exp_len: 832,  exp_err: 1'b0, rnd: 1'b1};
        tbl[5] = '{num: 5040, feed: 8190, exp_len: 8190, exp_err: 1'b0, rnd: 1'b0};
        tbl[6] = '{num: 5041, feed: 0,    exp_len: 0,    exp_err: 1'b1, rnd: 1'b0};
        tbl[7] = '{num: 8191, feed: 0,    exp_len: 0,    exp_err: 1'b1, rnd: 1'b0};

        #1;
        check("rst req_ready", {31'd0, req_ready}, 32'd1);
        check("rst xof_start", {31'd0, xof_start}, 32'd0);
        check("rst out_len", {19'd0, xof_out_len}, 32'd0);
        check("rst coef_valid", {31'd0, coef_valid}, 32'd0);
        check("rst xof_ready", {31'd0, xof_ready}, 32'd0);
        check("rst done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed data: word0 0123456789ABCDEF keep FF, word1 A5 keep 01 last.
        stream_b.delete();
        stream_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'hA5};
        run_txn("fixed5", 5, 9, 9, 1'b0, 1'b0);
        if (got_q.size() == 5) begin
            check("fixed coef0", {19'd0, got_q[0]}, 32'h0DEF);
            check("fixed coef1", {19'd0, got_q[1]}, 32'h0D5E);
            check("fixed coef4", {19'd0, got_q[4]}, 32'h1012);
        end else begin
            check("fixed count", got_q.size(), 32'd5);
        end

        for (int t = 0; t < 8; t++) begin
            fill_random(tbl[t].feed);
            run_txn($sformatf("tbl%0d", t), tbl[t].num, tbl[t].feed,
                    tbl[t].exp_len, tbl[t].exp_err, tbl[t].rnd);
        end

        // Stream ends after 64 bits while 10 coefficients were requested.
        fill_random(8);
        run_txn("short", 10, 8, 17, 1'b1, 1'b1);

        // Asynchronous reset in the middle of streaming.
        fill_random(13);
        @(negedge clk);
        req_valid     = 1'b1;
        req_num_coefs = 13'd8;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        xof_data  = 64'hFEDC_BA98_7654_3210;
        xof_keep  = 8'hFF;
        xof_last  = 1'b0;
        xof_valid = 1'b1;
        @(negedge clk);
        xof_valid = 1'b0;
        check("mid coef_valid", {31'd0, coef_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst coef_valid", {31'd0, coef_valid}, 32'd0);
        check("mid_rst coef_data", {19'd0, coef_data}, 32'd0);
        check("mid_rst xof_ready", {31'd0, xof_ready}, 32'd0);
        check("mid_rst out_len", {19'd0, xof_out_len}, 32'd0);
        check("mid_rst pulses", {29'd0, xof_start, done, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(5);
        run_txn("after_rst", 3, 5, 5, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
